// File: rtl/sa_aw_channel_split.sv
// rtl/sa_aw_channel_split.sv - AW round-robin arbiter with 4 KB INCR burst splitting
module sa_aw_channel_split #(
  parameter int MST_AMT           = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
  parameter int ADDR_W            = 32,
  parameter int TRANS_DATA_LEN_W  = 8,
  parameter int TRANS_DATA_SIZE_W = 3
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
  input  logic [ADDR_W*MST_AMT-1:0]              dsp_AWADDR_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
  input  logic [2*MST_AMT-1:0]                   dsp_AWBURST_i,
  input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
  output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
  output logic [ADDR_W-1:0]                      s_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
  output logic [1:0]                             s_AWBURST_o,
  output logic                                   s_AWVALID_o,
  input  logic                                   s_AWREADY_i,
  input  logic                                   AW_stall_i,
  output logic [TRANS_SLV_ID_W-1:0]              AW_AxID_o,
  output logic                                   AW_crossing_flag_o,
  output logic                                   AW_shift_en_o
);

  typedef enum logic [1:0] {IDLE, SEND, SEND2} state_t;

  state_t                          r_state, w_state_nxt;
  logic [MST_ID_W-1:0]             r_rr_ptr;
  logic                            r_valid;
  logic [TRANS_SLV_ID_W-1:0]       r_id;
  logic [ADDR_W-1:0]               r_addr;
  logic [TRANS_DATA_LEN_W-1:0]     r_len;
  logic [TRANS_DATA_LEN_W-1:0]     r_len2;
  logic [TRANS_DATA_SIZE_W-1:0]    r_size;
  logic [1:0]                      r_burst;
  logic                            r_split;

  logic                            w_req_any;
  logic [MST_ID_W-1:0]             w_grant;
  logic [MST_ID_W-1:0]             w_idx;
  logic                            w_accept;
  logic                            w_hs;
  logic [TRANS_MST_ID_W-1:0]       w_sel_id;
  logic [ADDR_W-1:0]               w_sel_addr;
  logic [TRANS_DATA_LEN_W-1:0]     w_sel_len;
  logic [TRANS_DATA_SIZE_W-1:0]    w_sel_size;
  logic [1:0]                      w_sel_burst;
  logic [16:0]                     w_bytes;
  logic [16:0]                     w_sum;
  logic                            w_split;
  logic [TRANS_DATA_LEN_W-1:0]     w_len1;
  logic [TRANS_DATA_LEN_W-1:0]     w_len2;
  logic [MST_ID_W-1:0]             w_rr_nxt;
  logic [ADDR_W-1:0]               w_next_page;

  // Circular search for the first requester at or after the round-robin pointer
  always_comb begin
    w_req_any = 1'b0;
    w_grant   = '0;
    w_idx     = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      w_idx = MST_ID_W'((int'(r_rr_ptr) + i) % MST_AMT);
      if (!w_req_any && dsp_AWVALID_i[w_idx]) begin
        w_req_any = 1'b1;
        w_grant   = w_idx;
      end
    end
  end

  assign w_accept = ARESETn_i && (r_state == IDLE) && w_req_any && !AW_stall_i;
  assign w_hs     = r_valid && s_AWREADY_i;

  always_comb begin
    dsp_AWREADY_o = '0;
    if (w_accept) dsp_AWREADY_o[w_grant] = 1'b1;
  end

  assign w_sel_id    = dsp_AWID_i[w_grant*TRANS_MST_ID_W +: TRANS_MST_ID_W];
  assign w_sel_addr  = dsp_AWADDR_i[w_grant*ADDR_W +: ADDR_W];
  assign w_sel_len   = dsp_AWLEN_i[w_grant*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
  assign w_sel_size  = dsp_AWSIZE_i[w_grant*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  assign w_sel_burst = dsp_AWBURST_i[w_grant*2 +: 2];

  // Burst byte count is kept wide enough that no legal LEN/SIZE pair can wrap
  assign w_bytes     = (17'(w_sel_len) + 17'd1) << w_sel_size;
  assign w_sum       = 17'(w_sel_addr[11:0]) + w_bytes;
  assign w_split     = (w_sel_burst == 2'b01) && (w_sum > 17'd4096);
  assign w_len1      = TRANS_DATA_LEN_W'(((13'd4096 - 13'(w_sel_addr[11:0])) >> w_sel_size) - 13'd1);
  assign w_len2      = w_sel_len - w_len1 - TRANS_DATA_LEN_W'(1);
  assign w_rr_nxt    = (int'(w_grant) == MST_AMT - 1) ? '0 : w_grant + MST_ID_W'(1);
  assign w_next_page = {r_addr[ADDR_W-1:12], 12'h000} + ADDR_W'(4096);

  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND:    if (w_hs)     w_state_nxt = r_split ? SEND2 : IDLE;
      SEND2:   if (w_hs)     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_len2   <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_split  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_rr_ptr <= w_rr_nxt;
          r_valid  <= 1'b1;
          r_id     <= {w_grant, w_sel_id};
          r_addr   <= w_sel_addr;
          r_len    <= w_split ? w_len1 : w_sel_len;
          r_len2   <= w_len2;
          r_size   <= w_sel_size;
          r_burst  <= w_sel_burst;
          r_split  <= w_split;
        end
        SEND: if (w_hs) begin
          r_valid <= 1'b0;
          if (r_split) begin
            r_addr <= w_next_page;
            r_len  <= r_len2;
          end
        end
        SEND2: begin
          // The B-stage FIFO may have filled from our first-half shift; wait it out
          if (!r_valid && !AW_stall_i) r_valid <= 1'b1;
          else if (w_hs)               r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign s_AWID_o           = r_id;
  assign s_AWADDR_o         = r_addr;
  assign s_AWLEN_o          = r_len;
  assign s_AWSIZE_o         = r_size;
  assign s_AWBURST_o        = r_burst;
  assign s_AWVALID_o        = r_valid;
  assign AW_AxID_o          = r_id;
  assign AW_crossing_flag_o = (r_state == SEND) && r_split;
  assign AW_shift_en_o      = w_hs;

endmodule
